clock_set_ctrl: RTL and testbench

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_set_ctrl.sv | 118 +++++++++++
 tb/tb_clock_set_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Time-setting controller for a clock: freezes the counter, edits hour/min/sec
// fields with inc/dec buttons, then loads the edited time back with a one-cycle strobe.
module clock_set_ctrl #(
  parameter int BLINK_DIV = 49999999
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_cancel,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       run_en,
  output logic       load,
  output logic [5:0] load_hour,
  output logic [5:0] load_min,
  output logic [5:0] load_sec,
  output logic [1:0] edit_field,
  output logic       blink
);

  localparam int CW = (BLINK_DIV < 1) ? 1 : $clog2(BLINK_DIV + 1);

  typedef enum logic [2:0] {RUN, SET_H, SET_M, SET_S, COMMIT} state_t;

  state_t        state, next_state;
  logic [5:0]    hour_q, min_q, sec_q;
  logic [CW-1:0] blink_cnt;
  logic          blink_q;
  logic          in_set, next_in_set, enter_set, accept_step;

  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] max_v,
                                           input logic up);
    if (up) return (v == max_v) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? max_v : v - 6'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= next_state;
  end

  // cancel beats mode beats inc/dec; COMMIT always falls back to RUN
  always_comb begin
    next_state = state;
    unique case (state)
      RUN:     if (btn_mode) next_state = SET_H;
      SET_H:   if (btn_cancel) next_state = RUN; else if (btn_mode) next_state = SET_M;
      SET_M:   if (btn_cancel) next_state = RUN; else if (btn_mode) next_state = SET_S;
      SET_S:   if (btn_cancel) next_state = RUN; else if (btn_mode) next_state = COMMIT;
      COMMIT:  next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  assign in_set      = (state == SET_H) || (state == SET_M) || (state == SET_S);
  assign next_in_set = (next_state == SET_H) || (next_state == SET_M) || (next_state == SET_S);
  assign enter_set   = next_in_set && (next_state != state);
  assign accept_step = in_set && !btn_cancel && !btn_mode && (btn_inc ^ btn_dec);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hour_q <= 6'd0;
      min_q  <= 6'd0;
      sec_q  <= 6'd0;
    end else if (state == RUN && btn_mode) begin
      hour_q <= cur_hour;
      min_q  <= cur_min;
      sec_q  <= cur_sec;
    end else if (accept_step) begin
      unique case (state)
        SET_H:   hour_q <= wrap_step(hour_q, 6'd23, btn_inc);
        SET_M:   min_q  <= wrap_step(min_q, 6'd59, btn_inc);
        SET_S:   sec_q  <= wrap_step(sec_q, 6'd59, btn_inc);
        default: ;
      endcase
    end
  end

  // Any field change or field switch restarts the flash with the field visible
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else if (!next_in_set) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else if (enter_set || accept_step) begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end else if (blink_cnt == CW'(BLINK_DIV)) begin
      blink_cnt <= '0;
      blink_q   <= ~blink_q;
    end else begin
      blink_cnt <= blink_cnt + CW'(1);
    end
  end

  always_comb begin
    edit_field = 2'b00;
    unique case (state)
      SET_H:   edit_field = 2'b01;
      SET_M:   edit_field = 2'b10;
      SET_S:   edit_field = 2'b11;
      default: edit_field = 2'b00;
    endcase
  end

  assign run_en    = (state == RUN);
  assign load      = (state == COMMIT);
  assign blink     = blink_q & in_set;
  assign load_hour = hour_q;
  assign load_min  = min_q;
  assign load_sec  = sec_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: a stage/field/age model checked every negedge,
// plus directed button sequences with literal expectations.
module tb_clock_set_ctrl;

  localparam int DIV = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_cancel = 1'b0;
  logic [5:0] cur_hour = 6'd12, cur_min = 6'd34, cur_sec = 6'd56;
  logic       run_en, load, blink;
  logic [5:0] load_hour, load_min, load_sec;
  logic [1:0] edit_field;

  int checks = 0;
  int failures = 0;
  int loadCount = 0;

  // model: stage 0 run, 1..3 editing hour/min/sec, 4 commit
  int mStage = 0, mH = 0, mM = 0, mS = 0, mAge = 0;

  clock_set_ctrl #(.BLINK_DIV(DIV)) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_cancel(btn_cancel),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .run_en(run_en), .load(load),
    .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
    .edit_field(edit_field), .blink(blink)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mStage <= 0; mH <= 0; mM <= 0; mS <= 0; mAge <= 0;
    end else if (mStage == 0) begin
      if (btn_mode) begin
        mStage <= 1; mH <= int'(cur_hour); mM <= int'(cur_min); mS <= int'(cur_sec); mAge <= 0;
      end
    end else if (mStage == 4) begin
      mStage <= 0;
    end else if (btn_cancel) begin
      mStage <= 0;
    end else if (btn_mode) begin
      mStage <= mStage + 1; mAge <= 0;
    end else if (btn_inc != btn_dec) begin
      if (mStage == 1)      mH <= (mH + (btn_inc ? 1 : 23)) % 24;
      else if (mStage == 2) mM <= (mM + (btn_inc ? 1 : 59)) % 60;
      else                  mS <= (mS + (btn_inc ? 1 : 59)) % 60;
      mAge <= 0;
    end else begin
      mAge <= mAge + 1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    automatic bit inSet = (mStage >= 1) && (mStage <= 3);
    if (load) loadCount <= loadCount + 1;
    checkOutput("m_run_en", int'(run_en), (mStage == 0) ? 1 : 0);
    checkOutput("m_load", int'(load), (mStage == 4) ? 1 : 0);
    checkOutput("m_edit_field", int'(edit_field), inSet ? mStage : 0);
    checkOutput("m_blink", int'(blink), (inSet && ((mAge / (DIV + 1)) % 2 == 0)) ? 1 : 0);
    checkOutput("m_load_hour", int'(load_hour), mH);
    checkOutput("m_load_min", int'(load_min), mM);
    checkOutput("m_load_sec", int'(load_sec), mS);
  end

  // Called at posedge+1: drives for one cycle, returns at the following posedge+1
  task automatic applyStimulus(input logic m, input logic i, input logic d, input logic c);
    btn_mode = m; btn_inc = i; btn_dec = d; btn_cancel = c;
    @(posedge clk); #1;
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; btn_cancel = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2 reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_run_en", int'(run_en), 1);
    checkOutput("rst_load", int'(load), 0);
    checkOutput("rst_edit_field", int'(edit_field), 0);
    checkOutput("rst_blink", int'(blink), 0);
    checkOutput("rst_load_hour", int'(load_hour), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    applyStimulus(1, 0, 0, 0);
    checkOutput("enter_edit_field", int'(edit_field), 1);
    checkOutput("enter_run_en", int'(run_en), 0);
    checkOutput("cap_hour", int'(load_hour), 12);
    checkOutput("cap_min", int'(load_min), 34);
    checkOutput("cap_sec", int'(load_sec), 56);
    checkOutput("enter_blink", int'(blink), 1);
    idle(3);
    checkOutput("blink_hold", int'(blink), 1);
    idle(1);
    checkOutput("blink_toggle", int'(blink), 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("inc_restart_blink", int'(blink), 1);
    checkOutput("hour_13", int'(load_hour), 13);
    for (int k = 0; k < 10; k++) applyStimulus(0, 1, 0, 0);
    checkOutput("hour_23", int'(load_hour), 23);
    idle(3);
    checkOutput("blink_period_hold", int'(blink), 1);
    idle(1);
    checkOutput("blink_period_off", int'(blink), 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("hour_wrap_up", int'(load_hour), 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("hour_wrap_down", int'(load_hour), 23);
    for (int k = 0; k < 6; k++) applyStimulus(0, 1, 0, 0);
    checkOutput("hour_5", int'(load_hour), 5);

    applyStimulus(1, 0, 0, 0);
    checkOutput("set_m_field", int'(edit_field), 2);
    for (int k = 0; k < 34; k++) applyStimulus(0, 0, 1, 0);
    checkOutput("min_0", int'(load_min), 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("min_wrap_down", int'(load_min), 59);
    applyStimulus(0, 1, 1, 0);
    checkOutput("min_both_ignored", int'(load_min), 59);
    applyStimulus(0, 1, 0, 0);
    checkOutput("min_wrap_up", int'(load_min), 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("mode_inc_field", int'(edit_field), 3);
    checkOutput("mode_inc_min", int'(load_min), 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 0);
    checkOutput("sec_59", int'(load_sec), 59);

    applyStimulus(1, 0, 0, 0);
    checkOutput("commit_load", int'(load), 1);
    checkOutput("commit_run_en", int'(run_en), 0);
    checkOutput("commit_hour", int'(load_hour), 5);
    checkOutput("commit_min", int'(load_min), 0);
    checkOutput("commit_sec", int'(load_sec), 59);
    applyStimulus(1, 0, 0, 1);
    checkOutput("post_commit_load", int'(load), 0);
    checkOutput("post_commit_run_en", int'(run_en), 1);
    checkOutput("post_commit_field", int'(edit_field), 0);
    applyStimulus(0, 1, 0, 1);
    checkOutput("run_ignores_field", int'(edit_field), 0);
    checkOutput("run_ignores_sec", int'(load_sec), 59);
    checkOutput("load_count_commit", loadCount, 1);

    cur_hour = 6'd1; cur_min = 6'd2; cur_sec = 6'd3;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("set_s_again", int'(edit_field), 3);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("cancel_run_en", int'(run_en), 1);
    checkOutput("cancel_field", int'(edit_field), 0);
    checkOutput("cancel_kept_sec", int'(load_sec), 4);
    idle(2);
    checkOutput("cancel_no_load", loadCount, 1);

    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 1);
    checkOutput("prio_cancel_field", int'(edit_field), 0);
    checkOutput("prio_cancel_hour", int'(load_hour), 1);

    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    reset = 1'b1;
    #1;
    checkOutput("async_rst_run_en", int'(run_en), 1);
    checkOutput("async_rst_load", int'(load), 0);
    checkOutput("async_rst_field", int'(edit_field), 0);
    checkOutput("async_rst_blink", int'(blink), 0);
    checkOutput("async_rst_sec", int'(load_sec), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(3);
    checkOutput("rst_no_load", loadCount, 1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("after_rst_field", int'(edit_field), 1);
    checkOutput("after_rst_hour", int'(load_hour), 1);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
